// File: rtl/imem_program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_program_loader_if
//  Description : Boot byte stream (valid/ready) plus the instruction-memory
//                write port of the program loader.
//                  byte_valid/byte_data : stream in, from the boot link
//                  byte_ready           : loader accepts a byte this cycle
//                  mem_we/addr/wdata    : word write toward the instruction RAM
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_program_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    // Loader side
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    // Boot link / memory side
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_program_loader
//  Description : Boot-time instruction-memory writer. Accepts a length header
//                (2 bytes, LE), then length*4 data bytes packed into LE words
//                written from word 0 upward, then one XOR checksum byte.
//                The core is held in reset until a load completes cleanly.
//  Ports       : clk, reset (sync, active high), start (load request),
//                bus (byte stream + memory write port), core_reset, busy,
//                done, error (sticky status until start or reset)
//  Revision    : 1.0  initial release
// ============================================================================
module imem_program_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  wire                         clk,
    input  wire                         reset,
    input  wire                         start,
    imem_program_loader_if.slave        bus,
    output logic                        core_reset,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [15:0] C_CAPACITY = 16'(2 ** ADDR_WIDTH);

    logic [2:0]            state_q,     state_d;
    logic [15:0]           len_q,       len_d;
    logic [ADDR_WIDTH:0]   word_idx_q,  word_idx_d;
    logic [1:0]            byte_idx_q,  byte_idx_d;
    logic [7:0]            csum_q,      csum_d;
    logic [31:0]           word_q,      word_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic        w_xfer;
    logic [15:0] w_len_full;
    logic [15:0] w_next_count;

    assign bus.byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                            (state_q == S_DATA)   || (state_q == S_CHECK);
    assign w_xfer       = bus.byte_valid && bus.byte_ready;
    assign w_len_full   = {bus.byte_data, len_q[7:0]};
    // word_idx is one bit wider than the address so a full 64-word load
    // compares against length without wrapping.
    assign w_next_count = 16'(word_idx_q) + 16'd1;

    assign bus.mem_we    = (state_q == S_WRITE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Status is decoded from the terminal states, which only start or reset
    // can leave, so done/error are sticky by construction.
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign core_reset = (state_q != S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) &&
                        (state_q != S_ERR);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        csum_d      = csum_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                    word_d     = '0;
                end
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    len_d[7:0] = bus.byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    len_d = w_len_full;
                    if (w_len_full > C_CAPACITY)
                        state_d = S_ERR;
                    else if (w_len_full == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    csum_d                     = csum_q ^ bus.byte_data;
                    word_d[byte_idx_q*8 +: 8]  = bus.byte_data;
                    byte_idx_d                 = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Latch the write port now so it is stable during WRITE
                        // and keeps its value afterwards.
                        state_d     = S_WRITE;
                        mem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = word_d;
                    end
                end
            end
            S_WRITE: begin
                if (w_next_count == len_q) begin
                    state_d = S_CHECK;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = S_DATA;
                end
            end
            S_CHECK: begin
                if (w_xfer)
                    state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            csum_q      <= csum_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_program_loader
//  Description : Directed bench for imem_program_loader; memory writes are
//                logged by a monitor and compared against hand-computed words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_program_loader;
    localparam int ADDR_WIDTH = 6;

    logic clk;
    logic reset;
    logic start;
    logic core_reset, busy, done, error;

    imem_program_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    imem_program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.slave),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int bad_ready_in_write = 0;

    logic [ADDR_WIDTH-1:0] log_addr[$];
    logic [31:0]           log_data[$];
    logic [7:0]            seq[$];

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.mem_we) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
            if (bus.byte_ready) bad_ready_in_write++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends seq[]; gapped=1 inserts (i+2)%4 idle cycles before byte i.
    // byte_valid stays high between back-to-back bytes, including across WRITE.
    task automatic send_seq(input bit gapped);
        for (int i = 0; i < seq.size(); i++) begin
            int gap;
            int tmo;
            gap = gapped ? ((i + 2) % 4) : 0;
            if (gap > 0) begin
                bus.byte_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = seq[i];
            tmo = 0;
            while (!bus.byte_ready && tmo < 20) begin
                @(posedge clk); #1;
                tmo++;
            end
            if (tmo >= 20) begin
                n_assert++;
                n_fail++;
                $display("FAIL handshake_timeout byte=%0d observed=ready_low expected=ready_high", i);
                bus.byte_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
    endtask

    initial begin
        int base;
        reset          = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // 1. Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_done",       32'(done), 32'd0);
        chk("rst_error",      32'(error), 32'd0);
        chk("rst_mem_we",     32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr",   32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata",  bus.mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 2. Two-word load, good checksum (0x71)
        pulse_start();
        chk("s2_busy_after_start", 32'(busy), 32'd1);
        seq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        send_seq(1'b0);
        chk("s2_write_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
            chk("s2_addr0", 32'(log_addr[0]), 32'd0);
            chk("s2_data0", log_data[0], 32'h00500093);
            chk("s2_addr1", 32'(log_addr[1]), 32'd1);
            chk("s2_data1", log_data[1], 32'h00A00113);
        end
        chk("s2_done",       32'(done), 32'd1);
        chk("s2_core_reset", 32'(core_reset), 32'd0);
        chk("s2_busy",       32'(busy), 32'd0);
        chk("s2_mem_addr_hold", 32'(bus.mem_addr), 32'd1);

        // 3. Same load, bad checksum
        base = log_addr.size();
        pulse_start();
        chk("s3_done_cleared", 32'(done), 32'd0);
        seq[10] = 8'h70;
        send_seq(1'b0);
        chk("s3_write_count", 32'(log_addr.size() - base), 32'd2);
        chk("s3_error",      32'(error), 32'd1);
        chk("s3_done",       32'(done), 32'd0);
        chk("s3_core_reset", 32'(core_reset), 32'd1);

        // 4a. Length 65 exceeds capacity -> ERR right after the header
        base = log_addr.size();
        pulse_start();
        seq = '{8'h41, 8'h00};
        send_seq(1'b0);
        chk("s4_oversize_error", 32'(error), 32'd1);
        chk("s4_oversize_busy",  32'(busy), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("s4_oversize_nowrite", 32'(log_addr.size() - base), 32'd0);

        // 4b. Zero-length load, checksum 00
        pulse_start();
        seq = '{8'h00, 8'h00, 8'h00};
        send_seq(1'b0);
        chk("s4_zero_done",    32'(done), 32'd1);
        chk("s4_zero_error",   32'(error), 32'd0);
        chk("s4_zero_nowrite", 32'(log_addr.size() - base), 32'd0);

        // 5. Gapped stream, valid held across WRITE where no gap
        base = log_addr.size();
        pulse_start();
        seq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        send_seq(1'b1);
        chk("s5_write_count", 32'(log_addr.size() - base), 32'd2);
        if (log_addr.size() - base == 2) begin
            chk("s5_data0", log_data[base],     32'h00500093);
            chk("s5_addr1", 32'(log_addr[base + 1]), 32'd1);
            chk("s5_data1", log_data[base + 1], 32'h00A00113);
        end
        chk("s5_done", 32'(done), 32'd1);
        chk("s5_ready_in_write", 32'(bad_ready_in_write), 32'd0);

        // 6. Reset after 3 bytes of word 1
        base = log_addr.size();
        pulse_start();
        seq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0};
        send_seq(1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("s6_core_reset", 32'(core_reset), 32'd1);
        chk("s6_busy",       32'(busy), 32'd0);
        chk("s6_ready",      32'(bus.byte_ready), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("s6_write_count", 32'(log_addr.size() - base), 32'd1);
        base = log_addr.size();
        pulse_start();
        seq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        send_seq(1'b0);
        chk("s6_reload_count", 32'(log_addr.size() - base), 32'd2);
        if (log_addr.size() - base == 2)
            chk("s6_reload_data1", log_data[base + 1], 32'h00A00113);
        chk("s6_reload_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
